// File: rtl/de_ex_pipe_reg.sv
// Decode-to-execute pipeline register with load-use bubble insertion and a
// taken-branch flush shadow. Optional perf counters under DE_EX_PERF_CNT_EN.
module de_ex_pipe_reg #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned CTRL_W       = 16,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_de,
    input  logic [XLEN-1:0]   pc_de,
    input  logic [XLEN-1:0]   pc_inc_de,
    input  logic [4:0]        rs1_de,
    input  logic [4:0]        rs2_de,
    input  logic [4:0]        rd_de,
    input  logic [XLEN-1:0]   ru_rs1_de,
    input  logic [XLEN-1:0]   ru_rs2_de,
    input  logic [XLEN-1:0]   imm_de,
    input  logic [CTRL_W-1:0] ctrl_de,
    input  logic              DMRd_de,
    input  logic              clr,
    input  logic              br_taken_ex,
    output logic              valid_ex,
    output logic [XLEN-1:0]   pc_ex,
    output logic [XLEN-1:0]   pc_inc_ex,
    output logic [4:0]        rs1_ex,
    output logic [4:0]        rs2_ex,
    output logic [4:0]        rd_ex,
    output logic [XLEN-1:0]   ru_rs1_ex,
    output logic [XLEN-1:0]   ru_rs2_ex,
    output logic [XLEN-1:0]   imm_ex,
    output logic [CTRL_W-1:0] ctrl_ex,
    output logic              DMRd_ex,
`ifdef DE_EX_PERF_CNT_EN
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
`endif
    output logic              flush_busy
);

    localparam int unsigned FCNT_W = 2;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_nxt;
    logic [FCNT_W-1:0] cnt_q;
    logic [FCNT_W-1:0] cnt_nxt;
    logic              squash_c;
    logic              bubble_c;

    // Flush-shadow next state; squash covers the branch edge and every FLUSH edge.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        squash_c  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (br_taken_ex) begin
                    squash_c = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt = ST_FLUSH;
                        cnt_nxt   = FCNT_W'(FLUSH_CYCLES - 1);
                    end
                end
            end
            ST_FLUSH: begin
                squash_c = 1'b1;
                if (cnt_q <= FCNT_W'(1)) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q - FCNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            flush_busy <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            flush_busy <= (state_nxt == ST_FLUSH);
        end
    end

    // Any of squash, load-use request or an empty decode slot yields a bubble.
    assign bubble_c = squash_c | clr | ~valid_de;

    // DMRd is active-low, so a bubble holds it at 1 and never re-triggers a stall.
    always_ff @(posedge clk) begin
        if (rst || bubble_c) begin
            valid_ex  <= 1'b0;
            pc_ex     <= '0;
            pc_inc_ex <= '0;
            rs1_ex    <= '0;
            rs2_ex    <= '0;
            rd_ex     <= '0;
            ru_rs1_ex <= '0;
            ru_rs2_ex <= '0;
            imm_ex    <= '0;
            ctrl_ex   <= '0;
            DMRd_ex   <= 1'b1;
        end else begin
            valid_ex  <= 1'b1;
            pc_ex     <= pc_de;
            pc_inc_ex <= pc_inc_de;
            rs1_ex    <= rs1_de;
            rs2_ex    <= rs2_de;
            rd_ex     <= rd_de;
            ru_rs1_ex <= ru_rs1_de;
            ru_rs2_ex <= ru_rs2_de;
            imm_ex    <= imm_de;
            ctrl_ex   <= ctrl_de;
            DMRd_ex   <= DMRd_de;
        end
    end

`ifdef DE_EX_PERF_CNT_EN
    logic clr_bubble_c;
    logic flush_start_c;

    // Only count bubbles owed to clr; a flush edge takes precedence.
    assign clr_bubble_c  = clr & ~squash_c;
    assign flush_start_c = (state_q == ST_RUN) & br_taken_ex;

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (clr_bubble_c && (bubble_cnt != {CNT_W{1'b1}})) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
            if (flush_start_c && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_de_ex_pipe_reg.sv
// Scoreboard bench for de_ex_pipe_reg; expected EX contents are pushed when
// decode stimulus is driven and popped after the capturing edge.
module tb_de_ex_pipe_reg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned CTRL_W       = 16;
    localparam int unsigned FLUSH_CYCLES = 2;
    localparam int unsigned CNT_W        = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_de;
    logic [XLEN-1:0]   pc_de, pc_inc_de, ru_rs1_de, ru_rs2_de, imm_de;
    logic [4:0]        rs1_de, rs2_de, rd_de;
    logic [CTRL_W-1:0] ctrl_de;
    logic              DMRd_de, clr, br_taken_ex;
    logic              valid_ex;
    logic [XLEN-1:0]   pc_ex, pc_inc_ex, ru_rs1_ex, ru_rs2_ex, imm_ex;
    logic [4:0]        rs1_ex, rs2_ex, rd_ex;
    logic [CTRL_W-1:0] ctrl_ex;
    logic              DMRd_ex, flush_busy;
`ifdef DE_EX_PERF_CNT_EN
    logic [CNT_W-1:0]  bubble_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    de_ex_pipe_reg #(
        .XLEN(XLEN), .CTRL_W(CTRL_W), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .valid_de(valid_de), .pc_de(pc_de), .pc_inc_de(pc_inc_de),
        .rs1_de(rs1_de), .rs2_de(rs2_de), .rd_de(rd_de), .ru_rs1_de(ru_rs1_de),
        .ru_rs2_de(ru_rs2_de), .imm_de(imm_de), .ctrl_de(ctrl_de), .DMRd_de(DMRd_de),
        .clr(clr), .br_taken_ex(br_taken_ex), .valid_ex(valid_ex), .pc_ex(pc_ex),
        .pc_inc_ex(pc_inc_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
        .ru_rs1_ex(ru_rs1_ex), .ru_rs2_ex(ru_rs2_ex), .imm_ex(imm_ex), .ctrl_ex(ctrl_ex),
        .DMRd_ex(DMRd_ex),
`ifdef DE_EX_PERF_CNT_EN
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
`endif
        .flush_busy(flush_busy)
    );

    typedef struct {
        logic              valid;
        logic [XLEN-1:0]   pc, pc_inc, ru1, ru2, imm;
        logic [4:0]        rs1, rs2, rd;
        logic [CTRL_W-1:0] ctrl;
        logic              dmrd;
        logic              busy;
        logic [CNT_W-1:0]  bcnt, fcnt;
    } exp_t;

    exp_t             sb_q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    int               squash_left = 0;
    logic [CNT_W-1:0] m_bcnt = '0;
    logic [CNT_W-1:0] m_fcnt = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
            return;
        end
        e = sb_q.pop_front();
        check("valid_ex",   64'(valid_ex),   64'(e.valid));
        check("pc_ex",      64'(pc_ex),      64'(e.pc));
        check("pc_inc_ex",  64'(pc_inc_ex),  64'(e.pc_inc));
        check("rs1_ex",     64'(rs1_ex),     64'(e.rs1));
        check("rs2_ex",     64'(rs2_ex),     64'(e.rs2));
        check("rd_ex",      64'(rd_ex),      64'(e.rd));
        check("ru_rs1_ex",  64'(ru_rs1_ex),  64'(e.ru1));
        check("ru_rs2_ex",  64'(ru_rs2_ex),  64'(e.ru2));
        check("imm_ex",     64'(imm_ex),     64'(e.imm));
        check("ctrl_ex",    64'(ctrl_ex),    64'(e.ctrl));
        check("DMRd_ex",    64'(DMRd_ex),    64'(e.dmrd));
        check("flush_busy", 64'(flush_busy), 64'(e.busy));
`ifdef DE_EX_PERF_CNT_EN
        check("bubble_cnt", 64'(bubble_cnt), 64'(e.bcnt));
        check("flush_cnt",  64'(flush_cnt),  64'(e.fcnt));
`endif
    endtask

    // Reference model: squash_left counts bubbles still owed to a taken branch.
    task automatic tick();
        exp_t e;
        e = '{valid: 1'b0, pc: '0, pc_inc: '0, ru1: '0, ru2: '0, imm: '0,
              rs1: '0, rs2: '0, rd: '0, ctrl: '0, dmrd: 1'b1, busy: 1'b0,
              bcnt: '0, fcnt: '0};
        if (rst) begin
            squash_left = 0;
            m_bcnt = '0;
            m_fcnt = '0;
        end else if (squash_left > 0) begin
            squash_left--;
        end else if (br_taken_ex) begin
            squash_left = FLUSH_CYCLES - 1;
            if (m_fcnt != {CNT_W{1'b1}}) m_fcnt = m_fcnt + 1'b1;
        end else if (clr) begin
            if (m_bcnt != {CNT_W{1'b1}}) m_bcnt = m_bcnt + 1'b1;
        end else if (valid_de) begin
            e.valid = 1'b1;   e.pc  = pc_de;     e.pc_inc = pc_inc_de;
            e.ru1 = ru_rs1_de; e.ru2 = ru_rs2_de; e.imm = imm_de;
            e.rs1 = rs1_de;   e.rs2 = rs2_de;   e.rd = rd_de;
            e.ctrl = ctrl_de; e.dmrd = DMRd_de;
        end
        e.busy = (squash_left > 0);
        e.bcnt = m_bcnt;
        e.fcnt = m_fcnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic rand_instr(input logic [XLEN-1:0] pc);
        valid_de    = 1'b1;
        pc_de       = pc;
        pc_inc_de   = pc + 32'd4;
        rs1_de      = 5'($urandom);
        rs2_de      = 5'($urandom);
        rd_de       = 5'($urandom_range(1, 31));
        ru_rs1_de   = $urandom;
        ru_rs2_de   = $urandom;
        imm_de      = $urandom;
        ctrl_de     = CTRL_W'($urandom) | CTRL_W'(1);
        DMRd_de     = 1'($urandom);
        clr         = 1'b0;
        br_taken_ex = 1'b0;
        rst         = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held two edges with busy inputs
        rand_instr(32'hDEAD_0000);
        rst = 1'b1; clr = 1'b1; br_taken_ex = 1'b1;
        tick();
        rand_instr(32'hBEEF_0000);
        rst = 1'b1;
        tick();

        rand_instr(32'h100);
        tick();

        // Load-use: load to x5, then dependent instruction stalled by clr
        rand_instr(32'h104); DMRd_de = 1'b0; rd_de = 5'd5;
        tick();
        rand_instr(32'h108); rs1_de = 5'd5; clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();

        // Taken branch: two bubbles, then the target is captured
        rand_instr(32'h10C); br_taken_ex = 1'b1;
        tick();
        rand_instr(32'h110);
        tick();
        rand_instr(32'h200);
        tick();

        // clr and branch together, second branch inside FLUSH ignored
        rand_instr(32'h204); clr = 1'b1; br_taken_ex = 1'b1;
        tick();
        rand_instr(32'h208); br_taken_ex = 1'b1; clr = 1'b1;
        tick();
        rand_instr(32'h300);
        tick();

        // Reset on the first FLUSH edge
        rand_instr(32'h304); br_taken_ex = 1'b1;
        tick();
        rand_instr(32'h308); rst = 1'b1;
        tick();
        rand_instr(32'h400);
        tick();

        // Empty decode slot and clr held over several edges
        rand_instr(32'h404); valid_de = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            rand_instr(32'h408); clr = 1'b1;
            tick();
        end
        rand_instr(32'h408);
        tick();

        // Bubble counter saturation (CNT_W=4): 14 pulses then 3 more
        rand_instr(32'h500); rst = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            rand_instr(32'h504); clr = 1'b1;
            tick();
            rand_instr(32'h504);
            tick();
`ifdef DE_EX_PERF_CNT_EN
            if (i == 13) check("bubble_cnt_preset", 64'(bubble_cnt), 64'hE);
`endif
        end
`ifdef DE_EX_PERF_CNT_EN
        check("bubble_cnt_sat", 64'(bubble_cnt), 64'hF);
`endif

        // Random mix
        for (int i = 0; i < 300; i++) begin
            rand_instr($urandom);
            valid_de    = ($urandom_range(0, 9) != 0);
            clr         = ($urandom_range(0, 5) == 0);
            br_taken_ex = ($urandom_range(0, 7) == 0);
            rst         = ($urandom_range(0, 40) == 0);
            tick();
        end

        if (sb_q.size() != 0) check("sb_leftover", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/de_ex_pipe_reg.md
Name: de_ex_pipe_reg

Overview:
- Decode-to-execute pipeline register of the segmented RISC-V core.
- Consumer end of the load-use stall/flush protocol. It takes the hazard unit's clr request and the execute-stage branch-taken flush, and turns them into bubbles in EX.
- Feeds rd_ex and DMRd_ex back to the hazard unit.
- Contains a flush-shadow state machine that squashes the wrong-path instructions following a taken branch.

Parameters:
- XLEN, 32, datapath width of PC, PC+4, register data and immediate.
- CTRL_W, 16, width of the packed control bundle excluding DMRd.
- FLUSH_CYCLES, 2, number of consecutive EX captures squashed per taken branch; legal range 1..3.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- valid_de  in  1  decode stage holds a real instruction.
- pc_de  in  XLEN  PC of the decode instruction.
- pc_inc_de  in  XLEN  PC+4 of the decode instruction.
- rs1_de  in  5  source register 1 index.
- rs2_de  in  5  source register 2 index.
- rd_de  in  5  destination register index.
- ru_rs1_de  in  XLEN  register-file read data for rs1.
- ru_rs2_de  in  XLEN  register-file read data for rs2.
- imm_de  in  XLEN  immediate.
- ctrl_de  in  CTRL_W  packed control: RUWr[0], DMWr[1], BrOp[6:2], remaining bits ALU/mux selects.
- DMRd_de  in  1  data-memory read, active-low (0 = load).
- clr  in  1  load-use bubble request from the hazard unit.
- br_taken_ex  in  1  taken branch/jump resolved in EX; starts a flush.
- valid_ex  out  1  EX holds a real instruction.
- pc_ex, pc_inc_ex, ru_rs1_ex, ru_rs2_ex, imm_ex  out  XLEN each  registered copies of the decode fields.
- rs1_ex, rs2_ex, rd_ex  out  5 each  registered indices; rd_ex also feeds the hazard unit.
- ctrl_ex  out  CTRL_W  registered control.
- DMRd_ex  out  1  registered active-low load flag; feeds the hazard unit.
- flush_busy  out  1  high while the FSM is in FLUSH.

Behaviour:
- Reset (rst=1 at a clock edge): all outputs 0 except DMRd_ex=1 (no load). FSM goes to RUN, flush counter 0.
- Latency: 1 cycle, decode inputs to _ex outputs. No stall input: this stage never holds, it either captures or inserts a bubble.
- Bubble definition: valid_ex=0, ctrl_ex=0 (RUWr=0, DMWr=0, BrOp=0), DMRd_ex=1, rd_ex=0, all other data fields 0. Because a bubble forces DMRd_ex=1, the hazard unit can never re-stall on a bubble.
- Capture priority per edge: rst > squash (br_taken_ex, or FSM in FLUSH) > clr > normal capture.
- Normal capture: all _de inputs are copied. valid_ex = valid_de. If valid_de=0, a bubble is loaded instead.
- FSM states:
  - RUN: br_taken_ex=1 → load bubble; if FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1, otherwise stay in RUN.
  - FLUSH: load bubble; cnt decrements; when cnt reaches 1 at an edge, return to RUN after that edge.
  - br_taken_ex is ignored in FLUSH, because a squashed instruction cannot branch. clr is ignored in FLUSH, since a bubble is loaded anyway.
- Simultaneous clr and br_taken_ex in RUN: a flush is started; the edge counts as one flush only.
- clr held across several edges: one bubble per edge.
- Reset mid-FLUSH: the FSM is forced to RUN, cnt=0, and the reset bubble values are applied.
- flush_busy = (state==FLUSH), registered.

Optional Feature:
- Macro DE_EX_PERF_CNT_EN.
- Defined: adds outputs bubble_cnt (CNT_W) and flush_cnt (CNT_W), both reset to 0.
  - bubble_cnt increments on each edge where clr=1 loads a bubble.
  - flush_cnt increments on each RUN→flush start.
  - Both saturate at all-ones.
- Not defined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst 2 cycles with arbitrary inputs → all outputs 0, DMRd_ex=1, flush_busy=0. After release, valid_de=1, pc_de=0x100 → next cycle pc_ex=0x100, valid_ex=1.
- Load-use: DMRd_de=0, rd_de=5, captured; then clr=1 for 1 cycle with rs1_de=5 → that edge gives valid_ex=0, rd_ex=0, DMRd_ex=1. Next edge with clr=0 captures the held decode instruction.
- Branch flush (FLUSH_CYCLES=2): br_taken_ex=1 at edge N → bubbles at N and N+1, flush_busy=1 after N only. At N+2 the instruction pc_de=0x200 is captured, valid_ex=1.
- Simultaneous clr=1 and br_taken_ex=1 in RUN → 2 bubbles; flush_cnt +1, bubble_cnt +0. Second br_taken_ex during FLUSH is ignored → no extension.
- Reset mid-flush: rst=1 at the first FLUSH edge → next edge state RUN, flush_busy=0, normal capture resumes.
- DE_EX_PERF_CNT_EN: bubble_cnt preset to 2^CNT_W-2 via stimulus of 2^CNT_W-2 clr pulses (CNT_W=4 build) → after 3 more clr pulses bubble_cnt=0xF, saturated.
